// File: rtl/plc_seq_ton_ctrl_if.sv
// Panel-side signal bundle for plc_seq_ton_ctrl: operator inputs in, channel drives and status out.
interface plc_seq_ton_ctrl_if #(
  parameter int N_CH = 3
);
  logic            start;
  logic            stop;
  logic            estop;
  logic            auto_mode;
  logic            man_mode;
  logic [N_CH-1:0] jog;
  logic [N_CH-1:0] ch_out;
  logic            running;
  logic            fault;
  logic [2:0]      state;

  modport master (
    output start, stop, estop, auto_mode, man_mode, jog,
    input  ch_out, running, fault, state
  );

  modport slave (
    input  start, stop, estop, auto_mode, man_mode, jog,
    output ch_out, running, fault, state
  );
endinterface

// File: rtl/plc_seq_ton_ctrl.sv
// Sequenced start/stop + TON controller for N_CH interlocked lathe outputs with E-stop fault latch.
// Optional macro REV_STOP_EN: stop ramps channels down in reverse order instead of dropping them all.
module plc_seq_ton_ctrl #(
  parameter int N_CH       = 3,
  parameter int TON_CYCLES = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  plc_seq_ton_ctrl_if.slave    bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RAMP_UP = 3'd1,
    RUN     = 3'd2,
    RAMP_DN = 3'd3,
    MANUAL  = 3'd4,
    FAULT   = 3'd5
  } state_t;

  localparam int            TW   = $clog2(TON_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TON_CYCLES - 1);

  state_t          state_r, state_s;
  logic [N_CH-1:0] ch_r, ch_s;
  logic [TW-1:0]   timer_r, timer_s;
  logic            start_prev_r;
  logic            running_r;
  logic            fault_r;

  logic            mode_auto_s;
  logic            mode_man_s;
  logic            start_edge_s;
  logic            timer_done_s;
  logic [N_CH-1:0] ch_up_s;
  logic [N_CH-1:0] jog_s;
  state_t          leave_s;

  assign mode_auto_s  = bus.auto_mode & ~bus.man_mode;
  assign mode_man_s   = bus.man_mode & ~bus.auto_mode;
  // start_prev_r resets to 0, so a start held through reset is accepted once.
  assign start_edge_s = bus.start & ~start_prev_r;
  assign timer_done_s = (timer_r >= TMAX);
  assign ch_up_s      = {ch_r[N_CH-2:0], 1'b1};
  // Feed/coolant demand is only honoured while the spindle jog is held.
  assign jog_s        = bus.jog & {N_CH{bus.jog[0]}};
  assign leave_s      = mode_man_s ? MANUAL : IDLE;

`ifdef REV_STOP_EN
  logic [N_CH-1:0] ch_dn_s;
  assign ch_dn_s = {1'b0, ch_r[N_CH-1:1]};
`endif

  // Next-state and next channel/timer values, estop first.
  always_comb begin
    state_s = state_r;
    ch_s    = ch_r;
    timer_s = '0;
    if (bus.estop) begin
      state_s = FAULT;
      ch_s    = '0;
    end else begin
      case (state_r)
        IDLE: begin
          ch_s = '0;
          if (bus.stop) begin
            state_s = IDLE;
          end else if (mode_man_s) begin
            state_s = MANUAL;
          end else if (mode_auto_s && start_edge_s) begin
            state_s = RAMP_UP;
            ch_s    = {{(N_CH-1){1'b0}}, 1'b1};
          end else begin
            state_s = IDLE;
          end
        end
        RAMP_UP, RUN: begin
          if (bus.stop) begin
`ifdef REV_STOP_EN
            ch_s    = ch_dn_s;
            state_s = (ch_dn_s == '0) ? IDLE : RAMP_DN;
`else
            ch_s    = '0;
            state_s = IDLE;
`endif
          end else if (!mode_auto_s) begin
            ch_s    = '0;
            state_s = leave_s;
          end else if (state_r == RUN) begin
            ch_s = ch_r;
          end else if (timer_done_s) begin
            ch_s    = ch_up_s;
            state_s = ch_up_s[N_CH-1] ? RUN : RAMP_UP;
          end else begin
            timer_s = timer_r + TW'(1);
          end
        end
`ifdef REV_STOP_EN
        RAMP_DN: begin
          if (!mode_auto_s) begin
            ch_s    = '0;
            state_s = leave_s;
          end else if (timer_done_s) begin
            ch_s    = ch_dn_s;
            state_s = (ch_dn_s == '0) ? IDLE : RAMP_DN;
          end else begin
            timer_s = timer_r + TW'(1);
          end
        end
`endif
        MANUAL: begin
          if (mode_man_s) begin
            ch_s = jog_s;
          end else begin
            ch_s    = '0;
            state_s = IDLE;
          end
        end
        FAULT: begin
          ch_s = '0;
          if (bus.stop) begin
            state_s = IDLE;
          end else begin
            state_s = FAULT;
          end
        end
        default: begin
          ch_s    = '0;
          state_s = IDLE;
        end
      endcase
    end
  end

  // State, channel, timer and status registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      ch_r         <= '0;
      timer_r      <= '0;
      start_prev_r <= 1'b0;
      running_r    <= 1'b0;
      fault_r      <= 1'b0;
    end else begin
      state_r      <= state_s;
      ch_r         <= ch_s;
      timer_r      <= timer_s;
      start_prev_r <= bus.start;
      running_r    <= (state_s == RAMP_UP) || (state_s == RUN) || (state_s == RAMP_DN);
      fault_r      <= (state_s == FAULT);
    end
  end

  assign bus.ch_out  = ch_r;
  assign bus.state   = state_r;
  assign bus.running = running_r;
  assign bus.fault   = fault_r;

endmodule

// File: tb/tb_plc_seq_ton_ctrl.sv
// Directed scoreboard bench for plc_seq_ton_ctrl at N_CH=3, TON_CYCLES=4.
module tb_plc_seq_ton_ctrl;
  localparam int N_CH = 3;
  localparam int TON  = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  plc_seq_ton_ctrl_if #(.N_CH(N_CH)) bus ();

  plc_seq_ton_ctrl #(.N_CH(N_CH), .TON_CYCLES(TON)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string      tag;
    logic [2:0] ch;
    logic [2:0] st;
    logic       run;
    logic       flt;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic step(input string tag, input logic [2:0] ch, input logic [2:0] st,
                      input logic run, input logic flt);
    exp_t e;
    e.tag = tag; e.ch = ch; e.st = st; e.run = run; e.flt = flt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    assert (bus.ch_out === e.ch) else begin
      errors++;
      $error("FAIL %s ch_out: got %b want %b", e.tag, bus.ch_out, e.ch);
    end
    checks++;
    assert (bus.state === e.st) else begin
      errors++;
      $error("FAIL %s state: got %0d want %0d", e.tag, bus.state, e.st);
    end
    checks++;
    assert (bus.running === e.run) else begin
      errors++;
      $error("FAIL %s running: got %b want %b", e.tag, bus.running, e.run);
    end
    checks++;
    assert (bus.fault === e.flt) else begin
      errors++;
      $error("FAIL %s fault: got %b want %b", e.tag, bus.fault, e.flt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.estop = 1'b0;
    bus.auto_mode = 1'b0; bus.man_mode = 1'b0; bus.jog = 3'b000;

    // reset
    step("rst0", 3'b000, 3'd0, 1'b0, 1'b0);
    step("rst1", 3'b000, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // auto ramp-up: 001 @+1, 011 @+5, 111 @+9
    bus.auto_mode = 1'b1;
    bus.start = 1'b1;
    step("up_c1", 3'b001, 3'd1, 1'b1, 1'b0);
    bus.start = 1'b0;
    for (int i = 2; i <= 4; i++) step("up_001", 3'b001, 3'd1, 1'b1, 1'b0);
    for (int i = 5; i <= 8; i++) step("up_011", 3'b011, 3'd1, 1'b1, 1'b0);
    step("up_111", 3'b111, 3'd2, 1'b1, 1'b0);
    step("run_hold", 3'b111, 3'd2, 1'b1, 1'b0);

    // start held high from RUN through stop must not retrigger
    bus.start = 1'b1;
    step("run_start", 3'b111, 3'd2, 1'b1, 1'b0);
    bus.stop = 1'b1;
`ifdef REV_STOP_EN
    step("dn_c1", 3'b011, 3'd3, 1'b1, 1'b0);
    bus.stop = 1'b0;
    for (int i = 2; i <= 4; i++) step("dn_011", 3'b011, 3'd3, 1'b1, 1'b0);
    step("dn_c5", 3'b001, 3'd3, 1'b1, 1'b0);
    for (int i = 6; i <= 8; i++) step("dn_001", 3'b001, 3'd3, 1'b1, 1'b0);
    step("dn_c9", 3'b000, 3'd0, 1'b0, 1'b0);
`else
    step("stop_idle", 3'b000, 3'd0, 1'b0, 1'b0);
    bus.stop = 1'b0;
`endif
    step("no_retrig0", 3'b000, 3'd0, 1'b0, 1'b0);
    step("no_retrig1", 3'b000, 3'd0, 1'b0, 1'b0);
    bus.start = 1'b0;
    step("idle_rest", 3'b000, 3'd0, 1'b0, 1'b0);

    // estop during ramp-up at 011
    bus.start = 1'b1;
    step("f_up1", 3'b001, 3'd1, 1'b1, 1'b0);
    bus.start = 1'b0;
    for (int i = 2; i <= 4; i++) step("f_up001", 3'b001, 3'd1, 1'b1, 1'b0);
    step("f_up011", 3'b011, 3'd1, 1'b1, 1'b0);
    bus.estop = 1'b1;
    step("fault_in", 3'b000, 3'd5, 1'b0, 1'b1);
    bus.estop = 1'b0; bus.start = 1'b1;
    step("fault_start", 3'b000, 3'd5, 1'b0, 1'b1);
    bus.start = 1'b0; bus.stop = 1'b1; bus.estop = 1'b1;
    step("fault_ack_estop", 3'b000, 3'd5, 1'b0, 1'b1);
    bus.estop = 1'b0;
    step("fault_ack", 3'b000, 3'd0, 1'b0, 1'b0);
    bus.stop = 1'b0;

    // manual mode with spindle interlock
    bus.auto_mode = 1'b0; bus.man_mode = 1'b1; bus.jog = 3'b110;
    step("man_enter", 3'b000, 3'd4, 1'b0, 1'b0);
    step("man_110", 3'b000, 3'd4, 1'b0, 1'b0);
    bus.jog = 3'b111;
    step("man_111", 3'b111, 3'd4, 1'b0, 1'b0);
    bus.jog = 3'b101;
    step("man_101", 3'b101, 3'd4, 1'b0, 1'b0);
    bus.jog = 3'b001;
    step("man_001", 3'b001, 3'd4, 1'b0, 1'b0);
    bus.man_mode = 1'b0; bus.auto_mode = 1'b1;
    step("man_to_auto", 3'b000, 3'd0, 1'b0, 1'b0);
    bus.jog = 3'b000;

    // invalid mode and start+stop together
    bus.man_mode = 1'b1; bus.start = 1'b1;
    step("both_modes", 3'b000, 3'd0, 1'b0, 1'b0);
    bus.man_mode = 1'b0; bus.start = 1'b0;
    step("auto_idle", 3'b000, 3'd0, 1'b0, 1'b0);
    bus.start = 1'b1; bus.stop = 1'b1;
    step("start_stop", 3'b000, 3'd0, 1'b0, 1'b0);
    bus.stop = 1'b0;
    step("start_held", 3'b000, 3'd0, 1'b0, 1'b0);
    bus.start = 1'b0;

    // leaving AUTO mid-ramp
    step("pre_leave", 3'b000, 3'd0, 1'b0, 1'b0);
    bus.start = 1'b1;
    step("leave_up1", 3'b001, 3'd1, 1'b1, 1'b0);
    bus.start = 1'b0; bus.auto_mode = 1'b0; bus.man_mode = 1'b1;
    step("leave_to_man", 3'b000, 3'd4, 1'b0, 1'b0);
    bus.man_mode = 1'b0;
    step("man_to_none", 3'b000, 3'd0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
